hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller in the decode stage of the five-stage processor. It works alongside the forwarding unit. It detects load-use hazards that forwarding cannot cover and issues stall/bubble controls for them. It also sequences multi-cycle control events: RET/RTI waits for the PC from memory, interrupt entry, and branch-taken flushes. It drives hold/flush controls for the PC, IF/ID and ID/EX registers.

Parameters:
RET_CYCLES, 3, cycles PC is frozen after a RET/RTI leaves decode (legal 1..15)
INT_CYCLES, 2, cycles of interrupt-entry sequence (legal 1..15)
CNT_W, 4, width of internal down-counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
src_ID  in  3  source register of instruction in decode
dst_ID  in  3  destination/second-operand register of instruction in decode
src_used  in  1  decode instruction reads src_ID
dst_used  in  1  decode instruction reads dst_ID
dst_EX  in  3  destination register of instruction in execute
MEM_R_EX  in  1  instruction in execute is a memory read (LDD/POP)
ret_ID  in  1  decode holds RET or RTI
branch_EX  in  1  taken branch/call resolved in execute
int_req  in  1  single-cycle interrupt request pulse
pc_stall  out  1  PC holds its value
ifid_stall  out  1  IF/ID holds its value
ifid_flush  out  1  IF/ID loads NOP
idex_flush  out  1  ID/EX loads NOP (bubble)
int_ack  out  1  one-cycle pulse, interrupt accepted
state_o  out  2  current state: 00 RUN, 01 RET_WAIT, 10 INT_SEQ

Behaviour:
- Reset (rst=1 at edge): state=RUN, cnt=0, int_pend=0. All outputs are forced to 0 while rst=1, regardless of the other inputs. Reset mid-sequence aborts the sequence; the block is in RUN in the cycle after rst drops.
- load_use = MEM_R_EX & ((src_used & src_ID==dst_EX) | (dst_used & dst_ID==dst_EX)). It is combinational, with zero-cycle latency.
- int_pend: set at the edge on which int_req=1. Cleared at the edge entering INT_SEQ; an int_req in that same cycle is dropped. An int_req while int_pend=1 has no additional effect.
- All outputs are combinational from state, cnt and inputs (Mealy). Unlisted outputs are 0.
- RUN, inputs evaluated in strict priority:
  1. branch_EX: ifid_flush=1, idex_flush=1; next=RUN. A coincident load_use, ret_ID or pending interrupt is not acted on this cycle.
  2. load_use: pc_stall=1, ifid_stall=1, idex_flush=1; next=RUN. The stall lasts exactly one cycle because the load advances to MEM, where forwarding covers it. ret_ID is re-evaluated next cycle.
  3. ret_ID: pc_stall=1, ifid_flush=1; next=RET_WAIT, cnt=RET_CYCLES-1.
  4. int_pend: pc_stall=1, ifid_flush=1, idex_flush=1; next=INT_SEQ, cnt=INT_CYCLES-1.
  5. Otherwise all outputs 0.
- RET_WAIT: pc_stall=1, ifid_flush=1. If cnt==0, next=RUN; else cnt-=1. branch_EX, load_use and ret_ID are ignored because only the RET and bubbles are in flight. An int_req arriving now stays pending.
- INT_SEQ: pc_stall=1, ifid_flush=1, idex_flush=1. int_ack=1 only in the first INT_SEQ cycle. If cnt==0, next=RUN; else cnt-=1. Other inputs are ignored.
- Latency from decode of RET to first unfrozen PC cycle: RET_CYCLES+1 cycles. Latency from accepting an interrupt to RUN: INT_CYCLES+1 cycles.
- The counter never wraps: it is only loaded on entry and stops at 0. With RET_CYCLES=1, RET_WAIT lasts one cycle.
- ifid_stall and ifid_flush are never both 1.
- state value 11 is unreachable; if ever entered, next=RUN with all outputs 0.

Test Plan:
- MEM_R_EX=1, dst_EX=3, src_ID=3, src_used=1 for one cycle -> pc_stall=ifid_stall=idex_flush=1 that cycle only. Repeat with src_used=0 -> all outputs 0.
- Same load-use condition with branch_EX=1 simultaneously -> ifid_flush=idex_flush=1, pc_stall=0, ifid_stall=0; state_o stays 00.
- ret_ID=1 in RUN, RET_CYCLES=3 -> pc_stall=ifid_flush=1 for 4 consecutive cycles; state_o=01 for 3 cycles, then 00 and outputs 0.
- int_req pulse during cycle 2 of RET_WAIT -> no int_ack until RET completes. On the first RUN cycle (no hazard), all three flush/stall outputs=1. The next cycle is state_o=10 with int_ack=1 for one cycle, then INT_SEQ lasts 2 cycles total, then RUN.
- rst=1 in the second RET_WAIT cycle -> outputs 0 while rst high; state_o=00, int_pend cleared; no residual stall after release.
- int_req and ret_ID together in RUN -> RET handled first, then interrupt accepted after RET_WAIT. Exactly one int_ack pulse.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard and sequencing controller: load-use stalls, branch flushes,
// RET/RTI PC-wait sequencing and interrupt entry, driving PC / IF/ID / ID/EX holds and flushes.
module hazard_ctrl #(
  parameter int RET_CYCLES = 3,
  parameter int INT_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] src_ID,
  input  logic [2:0] dst_ID,
  input  logic       src_used,
  input  logic       dst_used,
  input  logic [2:0] dst_EX,
  input  logic       MEM_R_EX,
  input  logic       ret_ID,
  input  logic       branch_EX,
  input  logic       int_req,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       int_ack,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    RET_WAIT = 2'b01,
    INT_SEQ  = 2'b10,
    ILLEGAL  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] RET_LOAD = CNT_W'(RET_CYCLES - 1);
  localparam logic [CNT_W-1:0] INT_LOAD = CNT_W'(INT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               int_pend_q, int_pend_d;
  logic               load_use;

  logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_flush_c, int_ack_c;

  assign load_use = MEM_R_EX & ((src_used & (src_ID == dst_EX)) |
                                (dst_used & (dst_ID == dst_EX)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    int_pend_d   = int_pend_q | int_req;
    pc_stall_c   = 1'b0;
    ifid_stall_c = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    int_ack_c    = 1'b0;

    case (state_q)
      RUN: begin
        if (branch_EX) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (load_use) begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (ret_ID) begin
          pc_stall_c   = 1'b1;
          ifid_flush_c = 1'b1;
          state_d      = RET_WAIT;
          cnt_d        = RET_LOAD;
        end else if (int_pend_q) begin
          pc_stall_c   = 1'b1;
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          state_d      = INT_SEQ;
          cnt_d        = INT_LOAD;
          // A request coinciding with acceptance is absorbed by this entry.
          int_pend_d   = 1'b0;
        end
      end

      RET_WAIT: begin
        pc_stall_c   = 1'b1;
        ifid_flush_c = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      INT_SEQ: begin
        pc_stall_c   = 1'b1;
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
        // The counter still holds its load value only in the first cycle.
        int_ack_c    = (cnt_q == INT_LOAD);
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_pend_q <= int_pend_d;
    end
  end

  assign pc_stall   = pc_stall_c   & ~rst;
  assign ifid_stall = ifid_stall_c & ~rst;
  assign ifid_flush = ifid_flush_c & ~rst;
  assign idex_flush = idex_flush_c & ~rst;
  assign int_ack    = int_ack_c    & ~rst;
  assign state_o    = rst ? 2'b00 : state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed output vectors checked by immediate assertions.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] src_ID, dst_ID, dst_EX;
  logic       src_used, dst_used, MEM_R_EX, ret_ID, branch_EX, int_req;
  logic       pc_stall, ifid_stall, ifid_flush, idex_flush, int_ack;
  logic [1:0] state_o;

  int compared   = 0;
  int mismatched = 0;

  // Expected vector layout: {pc_stall, ifid_stall, ifid_flush, idex_flush, int_ack, state_o}
  localparam logic [6:0] IDLE  = 7'b0000000;
  localparam logic [6:0] LU    = 7'b1101000;
  localparam logic [6:0] BR    = 7'b0011000;
  localparam logic [6:0] RETR  = 7'b1010000;
  localparam logic [6:0] RW    = 7'b1010001;
  localparam logic [6:0] INTA  = 7'b1011000;
  localparam logic [6:0] INT1  = 7'b1011110;
  localparam logic [6:0] INT2  = 7'b1011010;

  hazard_ctrl #(.RET_CYCLES(3), .INT_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .src_ID(src_ID), .dst_ID(dst_ID), .src_used(src_used), .dst_used(dst_used),
    .dst_EX(dst_EX), .MEM_R_EX(MEM_R_EX), .ret_ID(ret_ID), .branch_EX(branch_EX),
    .int_req(int_req),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .int_ack(int_ack), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [2:0] s_id, input logic [2:0] d_id,
                               input logic su, input logic du, input logic [2:0] d_ex,
                               input logic mr, input logic ret, input logic br, input logic ir);
    @(negedge clk);
    rst = r; src_ID = s_id; dst_ID = d_id; src_used = su; dst_used = du;
    dst_EX = d_ex; MEM_R_EX = mr; ret_ID = ret; branch_EX = br; int_req = ir;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] expected);
    logic [6:0] observed;
    observed = {pc_stall, ifid_stall, ifid_flush, idex_flush, int_ack, state_o};
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; src_ID = '0; dst_ID = '0; src_used = 1'b0; dst_used = 1'b0;
    dst_EX = '0; MEM_R_EX = 1'b0; ret_ID = 1'b0; branch_EX = 1'b0; int_req = 1'b0;

    // Reset masks outputs even with hazards present
    applyStimulus(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_masks_load_use", IDLE);
    applyStimulus(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_masks_branch_ret", IDLE);
    idle();
    checkOutput("after_reset_idle", IDLE);

    // Load-use detection
    applyStimulus(1'b0, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("load_use_src", LU);
    idle();
    checkOutput("load_use_one_cycle", IDLE);
    applyStimulus(1'b0, 3'd3, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("src_not_used", IDLE);
    applyStimulus(1'b0, 3'd5, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("load_use_dst", LU);
    applyStimulus(1'b0, 3'd3, 3'd3, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reg_mismatch", IDLE);
    applyStimulus(1'b0, 3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("no_mem_read", IDLE);

    // Branch outranks load-use
    applyStimulus(1'b0, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("branch_over_load_use", BR);
    idle();
    checkOutput("after_branch", IDLE);

    // Load-use outranks RET; RET taken the following cycle
    applyStimulus(1'b0, 3'd2, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("load_use_over_ret", LU);
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ret_decode", RETR);
    // Hazard inputs during RET_WAIT are ignored
    applyStimulus(1'b0, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("ret_wait_1_ignores", RW);
    idle();
    checkOutput("ret_wait_2", RW);
    idle();
    checkOutput("ret_wait_3", RW);
    idle();
    checkOutput("ret_done", IDLE);

    // Interrupt during RET_WAIT is deferred
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ret2_decode", RETR);
    idle();
    checkOutput("ret2_wait_1", RW);
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ret2_wait_2_intreq", RW);
    idle();
    checkOutput("ret2_wait_3", RW);
    idle();
    checkOutput("int_accept_after_ret", INTA);
    idle();
    checkOutput("int_seq_1_ack", INT1);
    idle();
    checkOutput("int_seq_2", INT2);
    idle();
    checkOutput("int_done", IDLE);

    // Reset mid RET_WAIT clears state and pending interrupt
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ret3_decode", RETR);
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ret3_wait_1_intreq", RW);
    applyStimulus(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_mid_ret_wait", IDLE);
    idle();
    checkOutput("post_rst_run", IDLE);
    idle();
    checkOutput("post_rst_no_int", IDLE);

    // RET and interrupt together: RET first, single ack afterwards
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("ret_int_together", RETR);
    idle();
    checkOutput("ret4_wait_1", RW);
    idle();
    checkOutput("ret4_wait_2", RW);
    idle();
    checkOutput("ret4_wait_3", RW);
    idle();
    checkOutput("int4_accept", INTA);
    idle();
    checkOutput("int4_ack", INT1);
    idle();
    checkOutput("int4_seq_2", INT2);
    idle();
    checkOutput("int4_done_single_ack", IDLE);

    // Pending interrupt waits out a branch; request at acceptance is dropped
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("intreq_not_yet_pending", IDLE);
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("branch_defers_int", BR);
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("int5_accept_with_req", INTA);
    idle();
    checkOutput("int5_ack", INT1);
    idle();
    checkOutput("int5_seq_2", INT2);
    idle();
    checkOutput("int5_done", IDLE);
    idle();
    checkOutput("dropped_req_no_reentry", IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
